// File: rtl/ats21_instr_capture.sv
// Instruction capture front-end for the ATS21 core: two-beat reassembly, Nop filtering,
// A-before-B ordering and a FWFT FIFO. Optional filter macro: ATS21_ILLEGAL_OP_FILTER_EN.
module ats21_instr_capture #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     req,
   input  logic [15:0]              ctrlA,
   input  logic [15:0]              ctrlB,
   output logic                     instr_valid,
   input  logic                     instr_ready,
   output logic                     instr_client,
   output logic [2:0]               instr_opcode,
   output logic [31:0]              instr_word,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     overflow,
   output logic                     illegal,
   output logic                     proto_err,
   output logic                     fsm_state
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef enum logic {IDLE = 1'b0, LOW = 1'b1} state_t;

   state_t        state, state_nxt;
   logic [15:0]   hi_a, hi_b;
   logic [31:0]   w_a, w_b;
   logic          is_low, valid_a, valid_b;
   logic          pend_valid;
   logic [31:0]   pend_word;
   logic          push, push_client, wr_en, pop, full;
   logic [31:0]   push_word;
   logic [32:0]   mem [DEPTH];
   logic [32:0]   head;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (req) state_nxt = LOW;
         LOW:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hi_a <= '0;
         hi_b <= '0;
      end else if (state == IDLE && req) begin
         hi_a <= ctrlA;
         hi_b <= ctrlB;
      end
   end

   assign is_low    = (state == LOW);
   assign fsm_state = is_low;
   assign w_a       = {hi_a, ctrlA};
   assign w_b       = {hi_b, ctrlB};
   // A request arriving during the lower-beat cycle is flagged but otherwise ignored.
   assign proto_err = is_low && req;

`ifdef ATS21_ILLEGAL_OP_FILTER_EN
   logic ill_a, ill_b;
   assign ill_a   = is_low && (w_a[31:29] == 3'b100);
   assign ill_b   = is_low && (w_b[31:29] == 3'b100);
   assign valid_a = is_low && (w_a[31:29] != 3'b000) && !ill_a;
   assign valid_b = is_low && (w_b[31:29] != 3'b000) && !ill_b;
   assign illegal = ill_a || ill_b;
`else
   assign valid_a = is_low && (w_a[31:29] != 3'b000);
   assign valid_b = is_low && (w_b[31:29] != 3'b000);
   assign illegal = 1'b0;
`endif

   // B of a pair waits one cycle; the next LOW is at least two cycles away.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend_valid <= 1'b0;
         pend_word  <= '0;
      end else begin
         pend_valid <= valid_a && valid_b;
         if (valid_a && valid_b) pend_word <= w_b;
      end
   end

   always_comb begin
      push        = 1'b0;
      push_client = 1'b0;
      push_word   = '0;
      if (valid_a) begin
         push      = 1'b1;
         push_word = w_a;
      end else if (valid_b) begin
         push        = 1'b1;
         push_client = 1'b1;
         push_word   = w_b;
      end else if (pend_valid) begin
         push        = 1'b1;
         push_client = 1'b1;
         push_word   = pend_word;
      end
   end

   assign full     = (count == FULL_CNT);
   assign pop      = (count != '0) && instr_ready;
   assign wr_en    = push && (!full || pop);
   assign overflow = push && full && !pop;

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= {push_client, push_word};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (pop)   rd_ptr <= rd_ptr + AW'(1);
         unique case ({wr_en, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Head is masked while empty so stale storage never reaches the core.
   assign head         = mem[rd_ptr];
   assign instr_valid  = (count != '0);
   assign instr_client = instr_valid && head[32];
   assign instr_word   = instr_valid ? head[31:0] : 32'h0;
   assign instr_opcode = instr_word[31:29];
   assign fifo_count   = count;

endmodule
